// File: rtl/spi_master_sequencer_pkg.sv
// Shared SPI definitions: sequencer state encoding, frame geometry and frame builder.
package spi_master_sequencer_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_e;

    // Reads carry an all-zero data byte; the slave drives miso during that phase.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] wdata
    );
        return {addr, rw, (rw ? {DATA_BITS{1'b0}} : wdata)};
    endfunction

endpackage

// File: rtl/spi_master_sequencer_clk_tick.sv
// Half-period divider: while enabled, pulses tick on every CLKDIV-th clk cycle.
module spi_clk_tick #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLKDIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: held at zero while disabled so every frame starts phase-aligned.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = 8'd0;
        end else if (cnt_q == LAST) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Tick decode from the registered count.
    always_comb begin
        tick = enable && (cnt_q == LAST);
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_sequencer.sv
// SPI mode-0 master: one 16-bit {addr, rw, data} frame per accepted command,
// with read data returned through a one-cycle response pulse.
module spi_master_sequencer
    import spi_master_sequencer_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rw,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 spi_cs,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    seq_state_e              state_q;
    logic [FRAME_BITS-2:0]   shift_q;
    logic [DATA_BITS-1:0]    rx_q;
    logic [4:0]              bit_cnt_q;
    logic                    rw_q;
    logic                    cs_q;
    logic                    sclk_q;
    logic                    mosi_q;
    logic                    rsp_valid_q;
    logic [DATA_BITS-1:0]    rsp_rdata_q;
    logic                    busy_q;
    logic                    ready_q;
    logic                    tick_s;
    logic [FRAME_BITS-1:0]   frame_s;

    spi_clk_tick #(.CLKDIV(CLKDIV)) u_clk_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (busy_q),
        .tick   (tick_s)
    );

    // Frame image of the command currently on the request port.
    always_comb begin
        frame_s = build_frame(cmd_rw, cmd_addr, cmd_wdata);
    end

    // Sequencer FSM; every bus and handshake output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= 5'd0;
            rw_q        <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        state_q   <= ST_SETUP;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        cs_q      <= 1'b0;
                        sclk_q    <= 1'b0;
                        rw_q      <= cmd_rw;
                        mosi_q    <= frame_s[FRAME_BITS-1];
                        shift_q   <= frame_s[FRAME_BITS-2:0];
                        bit_cnt_q <= 5'd0;
                        rx_q      <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tick_s) begin
                        state_q <= ST_SHIFT;
                        sclk_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        if (sclk_q) begin
                            // Falling edge: next bit out; the 16th fall opens HOLD.
                            sclk_q    <= 1'b0;
                            mosi_q    <= shift_q[FRAME_BITS-2];
                            shift_q   <= {shift_q[FRAME_BITS-3:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd15) begin
                                state_q <= ST_HOLD;
                            end
                        end else begin
                            sclk_q <= 1'b1;
                            if (bit_cnt_q >= 5'd8) begin
                                rx_q <= {rx_q[DATA_BITS-2:0], spi_miso};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        state_q     <= ST_GAP;
                        cs_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rw_q ? rx_q : {DATA_BITS{1'b0}};
                    end
                end
                ST_GAP: begin
                    if (tick_s) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        bit_cnt_q <= 5'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cs_q    <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign spi_cs    = cs_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;

endmodule
